// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter for the blackjack score, with bust flag.
// Optional LEADING_ZERO_BLANK_EN: leading zero digits output as 4'hF (blank).
module score_bcd_converter #(
    parameter int IN_WIDTH   = 6,
    parameter int DIGITS     = 2,
    parameter int BUST_LIMIT = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   score,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bust
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);
    localparam logic [31:0] LIMIT = BUST_LIMIT;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [SW-1:0] RST_BCD = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [SW-1:0] RST_BCD = '0;
`endif

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    state_t                state, state_nx;
    logic [IN_WIDTH-1:0]   shift_q, shift_nx;
    logic [SW-1:0]         scratch_q, scratch_nx;
    logic [CW-1:0]         cnt_q, cnt_nx;
    logic                  pend_q, pend_nx;
    logic [SW-1:0]         bcd_nx;
    logic                  bust_nx;
    logic [SW-1:0]         adj;
    logic [SW-1:0]         shifted;
    logic [SW-1:0]         shown;
    logic                  lead;

    assign busy = (state == CONVERT);
    assign done = (state == DONE);

    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
        shifted = {adj[SW-2:0], shift_q[IN_WIDTH-1]};
        shown = shifted;
        lead = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; stop blanking at first nonzero.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && shifted[4*k +: 4] == 4'h0)
                shown[4*k +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
    end

    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        scratch_nx = scratch_q;
        cnt_nx     = cnt_q;
        pend_nx    = pend_q;
        bcd_nx     = bcd_out;
        bust_nx    = bust;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    shift_nx   = score;
                    scratch_nx = '0;
                    cnt_nx     = '0;
                    pend_nx    = ({{(32-IN_WIDTH){1'b0}}, score} > LIMIT);
                    state_nx   = CONVERT;
                end else begin
                    state_nx = IDLE;
                end
            end
            CONVERT: begin
                scratch_nx = shifted;
                shift_nx   = shift_q << 1;
                cnt_nx     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_nx = DONE;
                    bcd_nx   = shown;
                    bust_nx  = pend_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            bcd_out   <= RST_BCD;
            bust      <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_q   <= shift_nx;
            scratch_q <= scratch_nx;
            cnt_q     <= cnt_nx;
            pend_q    <= pend_nx;
            bcd_out   <= bcd_nx;
            bust      <= bust_nx;
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed + randomized bench for score_bcd_converter against a decimal model.
// Honours LEADING_ZERO_BLANK_EN when defined for the build.
module tb_score_bcd_converter;

    localparam int IW = 6;
    localparam int D  = 2;
    localparam int BL = 21;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] RST_BCD = 8'hF0;
`else
    localparam logic [7:0] RST_BCD = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [IW-1:0] score;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd_out;
    logic          bust;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] prev_bcd;
    logic       prev_bust;

    score_bcd_converter #(
        .IN_WIDTH(IW), .DIGITS(D), .BUST_LIMIT(BL)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .score(score),
        .busy(busy), .done(done), .bcd_out(bcd_out), .bust(bust)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_bcd(input int s);
        int v;
        int dig[D];
        bit lead;
        logic [7:0] r;
        v = s;
        for (int k = 0; k < D; k++) begin
            dig[k] = v % 10;
            v = v / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int k = D - 1; k >= 1; k--) begin
            if (lead && dig[k] == 0) dig[k] = 15;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        r = '0;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'(dig[k]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            step();
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_bcd", 32'(bcd_out), 32'(prev_bcd));
            check("idle_bust", 32'(bust), 32'(prev_bust));
        end
    endtask

    // Starts in the current cycle; returns in the done cycle.
    task automatic do_conv(input int s, input int inj);
        logic [7:0] eb;
        logic       eu;
        eb = ref_bcd(s);
        eu = (s > BL);
        start = 1'b1;
        score = IW'(s);
        step();
        for (int i = 1; i <= IW; i++) begin
            score = IW'($urandom_range(0, 63));
            start = (i == inj);
            check("conv_busy", 32'(busy), 32'd1);
            check("conv_done", 32'(done), 32'd0);
            check("conv_bcd_held", 32'(bcd_out), 32'(prev_bcd));
            check("conv_bust_held", 32'(bust), 32'(prev_bust));
            step();
        end
        start = 1'b0;
        check("res_done", 32'(done), 32'd1);
        check("res_busy", 32'(busy), 32'd0);
        check("res_bcd", 32'(bcd_out), 32'(eb));
        check("res_bust", 32'(bust), 32'(eu));
        prev_bcd  = eb;
        prev_bust = eu;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        score = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'(RST_BCD));
        check("rst_bust", 32'(bust), 32'd0);
        prev_bcd  = RST_BCD;
        prev_bust = 1'b0;
        idle(1);

        do_conv(21, 0);
        idle(2);

        do_conv(22, 0);
        do_conv(63, 0);
        idle(1);

        do_conv(5, 0);
        idle(1);
        do_conv(0, 0);
        idle(1);

        do_conv(17, 3);
        idle(2);

        start = 1'b1;
        score = IW'(30);
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'(RST_BCD));
        check("abort_bust", 32'(bust), 32'd0);
        prev_bcd  = RST_BCD;
        prev_bust = 1'b0;
        idle(10);

        for (int s = 0; s < 64; s++) begin
            do_conv(s, 0);
            idle($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
